// File: rtl/cd_pkg.sv
// Shared constants and helpers for the cd_* blocks.
package cd_pkg;

  localparam int unsigned CD_TX_PAGES_MAX = 8;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned cd_clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/cd_tx_pages_if.sv
// Host-side write port and TX-side read port of the cd_tx_pages frame buffer.
interface cd_tx_pages_if
  import cd_pkg::*;
#(
  parameter int unsigned PAGES   = 2,
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned W_BYTES = 4
) ();

  localparam int unsigned WORD_AW = A_WIDTH - cd_clog2(W_BYTES);
  localparam int unsigned CNT_W   = cd_clog2(PAGES) + 1;

  logic [8*W_BYTES-1:0] wr_word;
  logic [WORD_AW-1:0]   wr_addr;
  logic                 wr_en;
  logic [A_WIDTH:0]     wr_len;
  logic                 switch;
  logic                 sw_nack;
  logic [A_WIDTH-1:0]   rd_addr;
  logic                 rd_en;
  logic [7:0]           rd_byte;
  logic [A_WIDTH:0]     rd_len;
  logic                 rd_done;
  logic                 unread;
  logic [CNT_W-1:0]     pending;
  logic                 full;

  // Host and TX engine together act as the master.
  modport master (
    output wr_word, wr_addr, wr_en, wr_len, switch, rd_addr, rd_en, rd_done,
    input  sw_nack, rd_byte, rd_len, unread, pending, full
  );

  modport slave (
    input  wr_word, wr_addr, wr_en, wr_len, switch, rd_addr, rd_en, rd_done,
    output sw_nack, rd_byte, rd_len, unread, pending, full
  );

endinterface

// File: rtl/cd_spram.sv
// Single-port RAM, active-low chip/write enables, registered read data.
// Read data only changes on a read access and holds otherwise. Not reset.
module cd_spram #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          cen,
  input  logic          wen,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Write when enabled with wen low, otherwise register a read.
  always_ff @(posedge clk) begin
    if (!cen) begin
      if (!wen) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/cd_tx_pages.sv
// Multi-page TX frame buffer between the host register interface and the
// bus TX engine. The host fills page wr_ptr and commits it with a length;
// the TX engine reads committed pages byte-wise in FIFO order and releases
// them. One page is always owned by the writer, so at most PAGES-1 pages
// are committed at once.
// Optional feature: define CD_TX_PAGES_FLUSH_EN to add a flush input that
// drops every committed page while keeping the page being written.
module cd_tx_pages
  import cd_pkg::*;
#(
  parameter int unsigned PAGES   = 2,
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned W_BYTES = 4
) (
  input logic         clk,
  input logic         reset_n,
`ifdef CD_TX_PAGES_FLUSH_EN
  input logic         flush,
`endif
  cd_tx_pages_if.slave bus
);

  localparam int unsigned PTR_W   = cd_clog2(PAGES);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned WB_BITS = cd_clog2(W_BYTES);
  localparam int unsigned WORD_AW = A_WIDTH - WB_BITS;
  localparam int unsigned LANE_W  = (WB_BITS == 0) ? 1 : WB_BITS;
  localparam int unsigned LEN_W   = A_WIDTH + 1;
  localparam int unsigned DW      = 8 * W_BYTES;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [LEN_W-1:0]  len_q [PAGES];
  logic [LEN_W-1:0]  len_d [PAGES];
  logic              sw_nack_q, sw_nack_d;
  logic              sw_ok, rd_ok;

  logic [PTR_W-1:0]  rd_sel_q;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [WORD_AW-1:0] rd_word;
  logic [DW-1:0]     page_rdata [PAGES];

  // Commit/release acceptance and pointer, count and length updates.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    for (int i = 0; i < int'(PAGES); i++) begin
      len_d[i] = len_q[i];
    end
    // Acceptance uses the registered count, before any same-cycle release.
    sw_ok     = bus.switch && (count_q < CNT_W'(PAGES - 1));
    rd_ok     = bus.rd_done && (count_q != '0);
    sw_nack_d = bus.switch && !sw_ok;

    if (sw_ok) begin
      len_d[wr_ptr_q] = bus.wr_len;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({sw_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

`ifdef CD_TX_PAGES_FLUSH_EN
    // Flush wins over switch/rd_done; the write page stays with the writer.
    if (flush) begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = wr_ptr_q;
      count_d   = '0;
      sw_nack_d = 1'b0;
      for (int i = 0; i < int'(PAGES); i++) begin
        len_d[i] = '0;
      end
    end
`endif
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sw_nack_q <= 1'b0;
      for (int i = 0; i < int'(PAGES); i++) begin
        len_q[i] <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      sw_nack_q <= sw_nack_d;
      for (int i = 0; i < int'(PAGES); i++) begin
        len_q[i] <= len_d[i];
      end
    end
  end

  assign rd_word = bus.rd_addr[A_WIDTH-1:WB_BITS];

  if (WB_BITS == 0) begin : g_lane_none
    assign lane_d = '0;
  end else begin : g_lane
    assign lane_d = bus.rd_addr[WB_BITS-1:0];
  end

  // Page and byte lane of the last read, so rd_byte holds until the next rd_en.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_sel_q <= '0;
      lane_q   <= '0;
    end else if (bus.rd_en) begin
      rd_sel_q <= rd_ptr_q;
      lane_q   <= lane_d;
    end
  end

  for (genvar p = 0; p < int'(PAGES); p++) begin : g_page
    logic               page_wr, page_rd;
    logic [WORD_AW-1:0] page_addr;

    assign page_wr   = bus.wr_en && (wr_ptr_q == PTR_W'(p));
    assign page_rd   = bus.rd_en && (rd_ptr_q == PTR_W'(p));
    // Write address wins when writer and reader share the page.
    assign page_addr = page_wr ? bus.wr_addr : rd_word;

    cd_spram #(
      .AW (WORD_AW),
      .DW (DW)
    ) u_ram (
      .clk   (clk),
      .cen   (!(page_wr || page_rd)),
      .wen   (!page_wr),
      .addr  (page_addr),
      .wdata (bus.wr_word),
      .rdata (page_rdata[p])
    );
  end

  // Status outputs and byte-lane extraction.
  always_comb begin
    bus.rd_byte = page_rdata[rd_sel_q][lane_q*8 +: 8];
    bus.pending = count_q;
    bus.unread  = (count_q != '0);
    bus.full    = (count_q == CNT_W'(PAGES - 1));
    bus.rd_len  = (count_q != '0) ? len_q[rd_ptr_q] : '0;
    bus.sw_nack = sw_nack_q;
  end

endmodule

// File: tb/tb_cd_tx_pages.sv
// Self-checking bench for cd_tx_pages with PAGES=4, A_WIDTH=8, W_BYTES=4.
// Reference model: a queue of committed frames (page, length) plus a byte
// image of every page.
module tb_cd_tx_pages;
  import cd_pkg::*;

  localparam int unsigned PAGES   = 4;
  localparam int unsigned A_WIDTH = 8;
  localparam int unsigned W_BYTES = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
`ifdef CD_TX_PAGES_FLUSH_EN
  logic flush = 1'b0;
`endif

  always #5 clk = ~clk;

  cd_tx_pages_if #(.PAGES(PAGES), .A_WIDTH(A_WIDTH), .W_BYTES(W_BYTES)) bus ();

  cd_tx_pages #(
    .PAGES   (PAGES),
    .A_WIDTH (A_WIDTH),
    .W_BYTES (W_BYTES)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef CD_TX_PAGES_FLUSH_EN
    .flush   (flush),
`endif
    .bus     (bus)
  );

  typedef struct {
    int page;
    int len;
  } frame_t;

  frame_t     committed[$];
  int         wr_page;
  logic [7:0] mem [PAGES][256];
  int         n_checks = 0;
  int         n_pass = 0;

  function automatic logic [8:0] exp_rd_len();
    return (committed.size() != 0) ? 9'(committed[0].len) : 9'd0;
  endfunction

  function automatic logic [7:0] exp_byte(input int a);
    return mem[committed[0].page][a];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [31:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 6'(a);
    bus.wr_word = d;
    cyc();
    bus.wr_en = 1'b0;
    for (int i = 0; i < 4; i++) mem[wr_page][a*4+i] = d[8*i +: 8];
  endtask

  task automatic read_byte(input int a, output logic [7:0] v);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 8'(a);
    cyc();
    bus.rd_en = 1'b0;
    v = bus.rd_byte;
  endtask

  // Drives one cycle of switch/rd_done/flush and advances the model.
  task automatic drive_ctl(input bit sw, input int len, input bit rel, input bit fl,
                           output bit exp_nack);
    bit acc, rel_ok;
    bus.switch  = sw;
    bus.wr_len  = 9'(len);
    bus.rd_done = rel;
`ifdef CD_TX_PAGES_FLUSH_EN
    flush = fl;
`endif
    cyc();
    bus.switch  = 1'b0;
    bus.rd_done = 1'b0;
`ifdef CD_TX_PAGES_FLUSH_EN
    flush = 1'b0;
`endif
    acc      = sw && !fl && (committed.size() < int'(PAGES) - 1);
    rel_ok   = rel && !fl && (committed.size() != 0);
    exp_nack = sw && !fl && !acc;
    if (fl) committed.delete();
    if (acc) begin
      committed.push_back('{page: wr_page, len: len & 511});
      wr_page = (wr_page + 1) % int'(PAGES);
    end
    if (rel_ok) void'(committed.pop_front());
  endtask

  task automatic test_reset();
    bus.wr_en = 0; bus.rd_en = 0; bus.switch = 0; bus.rd_done = 0;
    bus.wr_addr = '0; bus.wr_word = '0; bus.wr_len = '0; bus.rd_addr = '0;
    reset_n = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    committed.delete();
    wr_page = 0;
    cyc();
    n_checks++; if (bus.pending !== 3'd0) $display("FAIL reset_pending: got %0d want 0", bus.pending); else n_pass++;
    n_checks++; if (bus.unread !== 1'b0) $display("FAIL reset_unread: got %b want 0", bus.unread); else n_pass++;
    n_checks++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.full); else n_pass++;
    n_checks++; if (bus.rd_len !== 9'd0) $display("FAIL reset_rd_len: got %0d want 0", bus.rd_len); else n_pass++;
    n_checks++; if (bus.sw_nack !== 1'b0) $display("FAIL reset_sw_nack: got %b want 0", bus.sw_nack); else n_pass++;
  endtask

  task automatic test_fill_and_nack();
    bit nk;
    int lens [3] = '{10, 20, 30};
    for (int f = 0; f < 3; f++) begin
      write_word(f, $urandom);
      drive_ctl(1, lens[f], 0, 0, nk);
      n_checks++; if (bus.sw_nack !== nk) $display("FAIL fill_nack%0d: got %b want %b", f, bus.sw_nack, nk); else n_pass++;
    end
    n_checks++; if (bus.pending !== 3'd3) $display("FAIL fill_pending: got %0d want 3", bus.pending); else n_pass++;
    n_checks++; if (bus.full !== 1'b1) $display("FAIL fill_full: got %b want 1", bus.full); else n_pass++;
    n_checks++; if (bus.unread !== 1'b1) $display("FAIL fill_unread: got %b want 1", bus.unread); else n_pass++;
    n_checks++; if (bus.rd_len !== 9'd10) $display("FAIL fill_rd_len: got %0d want 10", bus.rd_len); else n_pass++;
    drive_ctl(1, 40, 0, 0, nk);
    n_checks++; if (bus.sw_nack !== 1'b1) $display("FAIL nack_pulse: got %b want 1", bus.sw_nack); else n_pass++;
    n_checks++; if (bus.pending !== 3'd3) $display("FAIL nack_pending: got %0d want 3", bus.pending); else n_pass++;
    cyc();
    n_checks++; if (bus.sw_nack !== 1'b0) $display("FAIL nack_one_cycle: got %b want 0", bus.sw_nack); else n_pass++;
  endtask

  task automatic test_full_switch_release();
    bit nk;
    drive_ctl(1, 50, 1, 0, nk);
    n_checks++; if (bus.sw_nack !== 1'b1) $display("FAIL full_sw_rel_nack: got %b want 1", bus.sw_nack); else n_pass++;
    n_checks++; if (bus.pending !== 3'(PAGES - 2)) $display("FAIL full_sw_rel_pending: got %0d want %0d", bus.pending, PAGES - 2); else n_pass++;
    n_checks++; if (bus.rd_len !== exp_rd_len()) $display("FAIL full_sw_rel_rd_len: got %0d want %0d", bus.rd_len, exp_rd_len()); else n_pass++;
  endtask

  task automatic test_drain_empty_release();
    bit nk;
    while (committed.size() != 0) drive_ctl(0, 0, 1, 0, nk);
    drive_ctl(0, 0, 1, 0, nk);
    n_checks++; if (bus.pending !== 3'd0) $display("FAIL empty_release_pending: got %0d want 0", bus.pending); else n_pass++;
    n_checks++; if (bus.rd_len !== 9'd0) $display("FAIL empty_release_rd_len: got %0d want 0", bus.rd_len); else n_pass++;
  endtask

  task automatic test_byte_lanes();
    bit nk;
    logic [7:0] v;
    logic [7:0] want [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    write_word(0, 32'h4433_2211);
    drive_ctl(1, 4, 0, 0, nk);
    n_checks++; if (bus.rd_len !== 9'd4) $display("FAIL lanes_rd_len: got %0d want 4", bus.rd_len); else n_pass++;
    for (int a = 0; a < 4; a++) begin
      read_byte(a, v);
      n_checks++; if (v !== want[a]) $display("FAIL lanes_byte%0d: got %02h want %02h", a, v, want[a]); else n_pass++;
    end
    cyc();
    n_checks++; if (bus.rd_byte !== 8'h44) $display("FAIL lanes_hold: got %02h want 44", bus.rd_byte); else n_pass++;
    drive_ctl(0, 0, 1, 0, nk);
  endtask

  task automatic test_simul_switch_release();
    bit nk;
    logic [7:0] v;
    int a;
    write_word(3, $urandom);
    drive_ctl(1, 5, 0, 0, nk);
    write_word(7, $urandom);
    drive_ctl(1, 7, 1, 0, nk);
    n_checks++; if (bus.sw_nack !== 1'b0) $display("FAIL simul_nack: got %b want 0", bus.sw_nack); else n_pass++;
    n_checks++; if (bus.pending !== 3'd1) $display("FAIL simul_pending: got %0d want 1", bus.pending); else n_pass++;
    n_checks++; if (bus.rd_len !== 9'd7) $display("FAIL simul_rd_len: got %0d want 7", bus.rd_len); else n_pass++;
    a = 28 + int'($urandom_range(0, 3));
    read_byte(a, v);
    n_checks++; if (v !== exp_byte(a)) $display("FAIL simul_data: got %02h want %02h", v, exp_byte(a)); else n_pass++;
    drive_ctl(0, 0, 1, 0, nk);
  endtask

  task automatic test_wrap();
    bit nk;
    logic [7:0] v;
    int w, len, a;
    for (int k = 0; k < 2 * int'(PAGES) + 1; k++) begin
      w   = int'($urandom_range(0, 63));
      len = int'($urandom_range(1, 256));
      write_word(w, $urandom);
      drive_ctl(1, len, 0, 0, nk);
      n_checks++; if (bus.rd_len !== exp_rd_len()) $display("FAIL wrap%0d_rd_len: got %0d want %0d", k, bus.rd_len, exp_rd_len()); else n_pass++;
      a = w * 4 + int'($urandom_range(0, 3));
      read_byte(a, v);
      n_checks++; if (v !== exp_byte(a)) $display("FAIL wrap%0d_data: got %02h want %02h", k, v, exp_byte(a)); else n_pass++;
      drive_ctl(0, 0, 1, 0, nk);
      n_checks++; if (bus.pending !== 3'(committed.size())) $display("FAIL wrap%0d_pending: got %0d want %0d", k, bus.pending, committed.size()); else n_pass++;
    end
  endtask

`ifdef CD_TX_PAGES_FLUSH_EN
  task automatic test_flush();
    bit nk;
    logic [7:0] v;
    write_word(1, $urandom);
    drive_ctl(1, 11, 0, 0, nk);
    write_word(2, $urandom);
    drive_ctl(1, 12, 0, 0, nk);
    n_checks++; if (bus.pending !== 3'd2) $display("FAIL flush_pre_pending: got %0d want 2", bus.pending); else n_pass++;
    write_word(5, 32'hDEAD_BEEF);
    drive_ctl(1, 9, 1, 1, nk);
    n_checks++; if (bus.pending !== 3'd0) $display("FAIL flush_pending: got %0d want 0", bus.pending); else n_pass++;
    n_checks++; if (bus.unread !== 1'b0) $display("FAIL flush_unread: got %b want 0", bus.unread); else n_pass++;
    n_checks++; if (bus.rd_len !== 9'd0) $display("FAIL flush_rd_len: got %0d want 0", bus.rd_len); else n_pass++;
    n_checks++; if (bus.sw_nack !== 1'b0) $display("FAIL flush_nack: got %b want 0", bus.sw_nack); else n_pass++;
    drive_ctl(1, 24, 0, 0, nk);
    n_checks++; if (bus.rd_len !== 9'd24) $display("FAIL flush_commit_len: got %0d want 24", bus.rd_len); else n_pass++;
    for (int a = 20; a < 24; a++) begin
      read_byte(a, v);
      n_checks++; if (v !== exp_byte(a)) $display("FAIL flush_data%0d: got %02h want %02h", a, v, exp_byte(a)); else n_pass++;
    end
    drive_ctl(0, 0, 1, 0, nk);
  endtask
`endif

  task automatic test_reset_midframe();
    bit nk;
    write_word(0, $urandom);
    drive_ctl(1, 33, 0, 0, nk);
    reset_n = 1'b0;
    #1;
    committed.delete();
    wr_page = 0;
    n_checks++; if (bus.pending !== 3'd0) $display("FAIL midreset_pending: got %0d want 0", bus.pending); else n_pass++;
    n_checks++; if (bus.rd_len !== 9'd0) $display("FAIL midreset_rd_len: got %0d want 0", bus.rd_len); else n_pass++;
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill_and_nack();
    test_full_switch_release();
    test_drain_empty_release();
    test_byte_lanes();
    test_simul_switch_release();
    test_wrap();
`ifdef CD_TX_PAGES_FLUSH_EN
    test_flush();
`endif
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cd_tx_pages.md
# cd_tx_pages

Parametrised multi-page TX frame buffer, placed between the host register interface and the bus TX state machine. The host writes a frame word-wise into the page it owns, then commits it with a length. The TX engine reads committed frames byte-wise in FIFO order and releases each page when transmission ends. Generalises dual-page ping-pong to PAGES pages, adding per-frame length tracking, occupancy reporting and commit rejection signalling.

## Interface
- PAGES, 2: number of frame pages; power of two, 2..8.
- A_WIDTH, 8: byte-address width per page (2^A_WIDTH bytes per page).
- W_BYTES, 4: bytes per write word; power of two, 1..8.
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_word  in  8*W_BYTES  write data, byte 0 in bits [7:0].
- wr_addr  in  A_WIDTH-log2(W_BYTES)  word address in the write page.
- wr_en  in  1  write strobe.
- wr_len  in  A_WIDTH+1  frame byte length, sampled on switch.
- switch  in  1  commit the write page.
- sw_nack  out  1  one-cycle pulse: switch rejected.
- rd_addr  in  A_WIDTH  byte address in the read page.
- rd_en  in  1  read strobe.
- rd_byte  out  8  read data.
- rd_len  out  A_WIDTH+1  length of the current read page; 0 when empty.
- rd_done  in  1  release the current read page.
- unread  out  1  pending != 0.
- pending  out  log2(PAGES)+1  committed, unreleased pages.
- full  out  1  pending == PAGES-1.

## Operation
- State: wr_ptr and rd_ptr (log2(PAGES) bits, wrap modulo PAGES), count (0..PAGES-1), len[PAGES] registers.
- The writer always owns page wr_ptr. Committed pages are rd_ptr .. rd_ptr+count-1.
- switch accepted iff registered count < PAGES-1: len[wr_ptr] <= wr_len, wr_ptr++, count++. Otherwise the commit is dropped, sw_nack pulses the next cycle, and the page is unchanged.
- rd_done accepted iff count != 0: rd_ptr++, count--. rd_done when empty is ignored, with no flag.
- Simultaneous accepted switch and rd_done: count unchanged; both pointers advance.
- The acceptance test for switch uses the count before any same-cycle release. At full, switch together with rd_done is rejected.
- Write enable applies to page wr_ptr only. Read enable applies to page rd_ptr only.
- When count==0, rd_ptr==wr_ptr. A same-cycle wr_en and rd_en then gives the write address priority, and rd_byte is unspecified for that read.
- wr_len is not range-checked. Values above 2^A_WIDTH are stored truncated to A_WIDTH+1 bits.
- rd_len = len[rd_ptr] when count != 0, else 0.

## Timing
- Reset values: wr_ptr=rd_ptr=0, count=0, all len=0, sw_nack=0, unread=0, pending=0, full=0, rd_len=0. rd_byte is unspecified until the first rd_en, because the RAM is not reset.
- Write: 1 cycle. Data is visible to a read issued on the next cycle.
- Read latency is 1. rd_addr is sampled with rd_en. The byte-lane select rd_addr[log2(W_BYTES)-1:0] is registered alongside.
- rd_byte is valid the cycle after rd_en and holds until the next rd_en.
- pending, unread, full and rd_len update the cycle after switch or rd_done.
- Reset mid-frame discards all pages; no recovery of contents.

## Configuration
- CD_TX_PAGES_FLUSH_EN defined: adds input port flush (1 bit). A flush pulse sets count<=0, rd_ptr<=wr_ptr and clears all len.
- flush has priority over same-cycle switch and rd_done; both are ignored, and sw_nack is not raised.
- The page being written is kept and remains owned by the writer.
- Undefined: the port is absent and no flush logic is generated.

## Structure
- Shared package cd_pkg: CD_TX_PAGES_MAX=8 and function cd_clog2.
- Page RAMs: one existing cd_spram instance per page (A_WIDTH-log2(W_BYTES) address bits, 8*W_BYTES data bits), in a generate loop, with active-low cen/wen derived from the per-page read/write enables.
- No new sub-module. Pointer and count logic stays in cd_tx_pages.

## Test plan
- PAGES=4: write 3 frames (lengths 10, 20, 30) with switch each time. Expect pending=3, full=1. A 4th switch produces sw_nack=1 for one cycle, and pending stays 3.
- Write 0x44332211 at word 0, switch with wr_len=4. Reads of rd_addr 0..3 give 0x11, 0x22, 0x33, 0x44, each one cycle after rd_en. rd_len=4.
- At full, assert switch and rd_done together. Expect the switch rejected (sw_nack) and pending=PAGES-2.
- Not full, count=1, switch and rd_done together. Expect pending to stay 1 and rd_len to show the newly committed frame's length.
- Run 2*PAGES+1 commit/release cycles. Pointers wrap, and data and length stay correct per page.
- With CD_TX_PAGES_FLUSH_EN and pending=2, pulse flush together with rd_done. Expect pending=0, unread=0, rd_len=0. Write-page data written before the flush is readable after the next commit.
